led_matrix_pwm_driver: RTL and testbench

- Parametrised successor to the board's fixed 8x4 multiplexed LED display driver.
- Scans an N_ROWS x N_COLS LED matrix column by column, with per-pixel PWM brightness and a global dimmer.
- Inserts anti-ghosting blanking between columns.
- Takes frames through a valid/ready double-buffered interface, so the SoC or debug logic can update the picture without tearing.
- Sits between the SoC debug/LED signals and the board pins.

---
 rtl/led_matrix_pwm_driver.sv | 182 ++++++++++++++++++
 tb/tb_led_matrix_pwm_driver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_pwm_driver.sv
// Purpose : scans an N_ROWS x N_COLS LED matrix one column at a time, with per-pixel PWM,
//           a global dimmer, and all-off blanking at the start of every column slot.
// Latency : every output is registered and shows the scan state one clk after it is reached;
//           a frame accepted on fb_valid & fb_ready is shown from the next column-0 boundary.
// Backpressure: fb_ready drops while a captured frame waits in the shadow buffer and rises
//           again the cycle after the shadow is moved into the active buffer.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   fb_data/valid/ready frame input; pixel (c,r) = fb_data[(c*N_ROWS+r)*PWM_BITS +: PWM_BITS]
//   global_dim          brightness ceiling, latched as each column slot begins its blanking
//   rows, cols          matrix drive, polarity set by ROW_ACTIVE_LOW / COL_ACTIVE_LOW
//   frame_start         one-cycle pulse on the first blank cycle of column 0
module led_matrix_pwm_driver #(
  parameter int N_ROWS       = 8,
  parameter int N_COLS       = 4,
  parameter int PWM_BITS     = 3,
  parameter int TICK_DIV     = 375,
  parameter int BLANK_CYCLES = 8,
  parameter bit ROW_ACTIVE_LOW = 1'b0,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_COLS*N_ROWS*PWM_BITS-1:0]   fb_data,
  input  logic                                fb_valid,
  output logic                                fb_ready,
  input  logic [PWM_BITS-1:0]                 global_dim,
  output logic [N_ROWS-1:0]                   rows,
  output logic [N_COLS-1:0]                   cols,
  output logic                                frame_start
);

  localparam int FB_W = N_COLS * N_ROWS * PWM_BITS;
  localparam int CW   = (N_COLS > 1)       ? $clog2(N_COLS)       : 1;
  localparam int TW   = (TICK_DIV > 1)     ? $clog2(TICK_DIV)     : 1;
  localparam int BW   = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [CW-1:0]       COL_LAST   = CW'(N_COLS - 1);
  localparam logic [TW-1:0]       TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0]       BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST   = '1;

  // XOR masks turning an "active" bit vector into pin levels.
  localparam logic [N_ROWS-1:0] ROWS_OFF = {N_ROWS{ROW_ACTIVE_LOW}};
  localparam logic [N_COLS-1:0] COLS_OFF = {N_COLS{COL_ACTIVE_LOW}};

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [BW-1:0]       blank_cnt_q, blank_cnt_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] dim_lat_q, dim_lat_d;
  logic [FB_W-1:0]     shadow_q, shadow_d;
  logic [FB_W-1:0]     active_q, active_d;
  logic                pending_q, pending_d;
  logic                fb_ready_q, fb_ready_d;
  logic [N_ROWS-1:0]   rows_q, rows_d;
  logic [N_COLS-1:0]   cols_q, cols_d;
  logic                frame_start_q, frame_start_d;

  logic                slot_end;
  logic                frame_wrap;
  logic [PWM_BITS-1:0] pix;
  logic [N_ROWS-1:0]   lit;
  logic [N_COLS-1:0]   col_sel;

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    blank_cnt_d   = blank_cnt_q;
    tick_cnt_d    = tick_cnt_q;
    pwm_cnt_d     = pwm_cnt_q;
    dim_lat_d     = dim_lat_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    pending_d     = pending_q;
    pix           = '0;
    lit           = '0;
    col_sel       = '0;

    slot_end   = (state_q == ST_ON) && (tick_cnt_q == TICK_LAST) && (pwm_cnt_q == PWM_LAST);
    frame_wrap = slot_end && (col_q == COL_LAST);

    // Scan sequencing
    case (state_q)
      ST_BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          state_d     = ST_ON;
          blank_cnt_d = '0;
          tick_cnt_d  = '0;
          pwm_cnt_d   = '0;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      default: begin
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          if (pwm_cnt_q == PWM_LAST) begin
            state_d   = ST_BLANK;
            pwm_cnt_d = '0;
            col_d     = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
            // Latching here keeps a dimmer change from reshaping a slot already lit.
            dim_lat_d = global_dim;
          end else begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
    endcase

    // Double buffer: the swap looks at pending_q, so a frame captured on the
    // boundary edge itself waits for the following boundary.
    if (frame_wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (fb_valid && fb_ready_q) begin
      shadow_d  = fb_data;
      pending_d = 1'b1;
    end
    fb_ready_d = !pending_d;

    // Output decode from the current scan state
    if (state_q == ST_ON) begin
      col_sel[col_q] = 1'b1;
      for (int r = 0; r < N_ROWS; r++) begin
        pix    = active_q[(int'(col_q) * N_ROWS + r) * PWM_BITS +: PWM_BITS];
        lit[r] = (pwm_cnt_q < pix) && (pwm_cnt_q < dim_lat_q);
      end
    end
    rows_d        = lit ^ ROWS_OFF;
    cols_d        = col_sel ^ COLS_OFF;
    frame_start_d = (state_q == ST_BLANK) && (blank_cnt_q == '0) && (col_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BLANK;
      col_q         <= '0;
      blank_cnt_q   <= '0;
      tick_cnt_q    <= '0;
      pwm_cnt_q     <= '0;
      dim_lat_q     <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      fb_ready_q    <= 1'b1;
      rows_q        <= ROWS_OFF;
      cols_q        <= COLS_OFF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      blank_cnt_q   <= blank_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      dim_lat_q     <= dim_lat_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      fb_ready_q    <= fb_ready_d;
      rows_q        <= rows_d;
      cols_q        <= cols_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign fb_ready    = fb_ready_q;
  assign rows        = rows_q;
  assign cols        = cols_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_pwm_driver.sv
// Directed bench for led_matrix_pwm_driver with TICK_DIV=1, BLANK_CYCLES=2:
// slot = 10 clocks (2 blank + 8 on), frame = 40 clocks.
module tb_led_matrix_pwm_driver;

  localparam int NR    = 8;
  localparam int NC    = 4;
  localparam int PB    = 3;
  localparam int FW    = NR * NC * PB;
  localparam int SLOT  = 10;
  localparam int FRAME = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] fb_data = '0;
  logic          fb_valid = 1'b0;
  logic          fb_ready;
  logic [PB-1:0] global_dim = 3'd7;
  logic [NR-1:0] rows;
  logic [NC-1:0] cols;
  logic          frame_start;

  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk = ~clk;

  // Clock edges since reset released; output offset in the frame is (cyc-1) mod 40.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  led_matrix_pwm_driver #(
    .N_ROWS(NR), .N_COLS(NC), .PWM_BITS(PB), .TICK_DIV(1), .BLANK_CYCLES(2),
    .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .fb_data(fb_data), .fb_valid(fb_valid), .fb_ready(fb_ready),
    .global_dim(global_dim), .rows(rows), .cols(cols), .frame_start(frame_start)
  );

  function automatic int cur_off();
    return (cyc - 1) % FRAME;
  endfunction

  // Column drive expected at frame offset o (active-low, blank for 2 clocks per slot).
  function automatic logic [3:0] exp_cols(input int o);
    if ((o % SLOT) < 2) return 4'hF;
    return ~(4'b0001 << (o / SLOT));
  endfunction

  // Row bit r lit in column c's ON phase for the first lvl PWM steps.
  function automatic logic [7:0] pulse(input int o, input int c, input int r, input int lvl);
    int p;
    p = o % SLOT;
    if ((o / SLOT) == c && p >= 2 && (p - 2) < lvl) return 8'(1 << r);
    return 8'h00;
  endfunction

  task automatic wait_off(input int o);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cur_off() != o && n < 2 * FRAME);
    checks++;
    if (cur_off() != o) begin
      errors++;
      $display("FAIL wait_off: reached offset %0d, required %0d", cur_off(), o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rows !== 8'h00) begin errors++; $display("FAIL reset_rows: got %h want 00", rows); end
    checks++; if (cols !== 4'hF) begin errors++; $display("FAIL reset_cols: got %h want f", cols); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    checks++; if (fb_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", fb_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL first_fs: got %b want 1", frame_start); end
    checks++; if (cols !== 4'hF) begin errors++; $display("FAIL first_cols: got %h want f", cols); end
  endtask

  task automatic test_scan();
    int o;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      @(negedge clk);
      o = cur_off();
      checks++; if (cols !== exp_cols(o)) begin errors++; $display("FAIL scan_cols o=%0d: got %h want %h", o, cols, exp_cols(o)); end
      checks++; if (rows !== 8'h00) begin errors++; $display("FAIL scan_rows o=%0d: got %h want 00", o, rows); end
      checks++; if (frame_start !== (o == 0)) begin errors++; $display("FAIL scan_fs o=%0d: got %b want %b", o, frame_start, (o == 0)); end
    end
  endtask

  task automatic test_pwm_duty();
    logic [FW-1:0] f;
    int o, n;
    f = '0;
    f[(1 * NR + 3) * PB +: PB] = 3'd5;
    wait_off(20);
    fb_data = f; fb_valid = 1'b1;
    @(negedge clk);
    fb_valid = 1'b0;
    wait_off(0);
    wait_off(11);
    n = 0;
    for (int k = 12; k <= 19; k++) begin
      @(negedge clk);
      o = cur_off();
      if (rows[3]) n++;
      checks++; if (rows !== pulse(o, 1, 3, 5)) begin errors++; $display("FAIL duty_rows o=%0d: got %h want %h", o, rows, pulse(o, 1, 3, 5)); end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL duty_count: got %0d want 5", n); end
  endtask

  task automatic test_global_dim();
    int o, n;
    wait_off(30);
    global_dim = 3'd2;
    wait_off(11);
    n = 0;
    for (int k = 12; k <= 19; k++) begin
      @(negedge clk);
      o = cur_off();
      if (rows[3]) n++;
      checks++; if (rows !== pulse(o, 1, 3, 2)) begin errors++; $display("FAIL dim2_rows o=%0d: got %h want %h", o, rows, pulse(o, 1, 3, 2)); end
      if (o == 14) global_dim = 3'd7;
    end
    checks++; if (n != 2) begin errors++; $display("FAIL dim2_count: got %0d want 2", n); end
    wait_off(11);
    n = 0;
    for (int k = 12; k <= 19; k++) begin
      @(negedge clk);
      o = cur_off();
      if (rows[3]) n++;
      checks++; if (rows !== pulse(o, 1, 3, 5)) begin errors++; $display("FAIL dim7_rows o=%0d: got %h want %h", o, rows, pulse(o, 1, 3, 5)); end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL dim7_count: got %0d want 5", n); end
  endtask

  // Frame A offered mid-frame, then B offered while A is pending (must be dropped).
  task automatic test_back_to_back();
    logic [FW-1:0] fa, fbb;
    int o;
    fa = '0;  fa[(0 * NR + 0) * PB +: PB] = 3'd7;  fa[(3 * NR + 6) * PB +: PB] = 3'd7;
    fbb = '0; fbb[(2 * NR + 2) * PB +: PB] = 3'd7;
    wait_off(20);
    checks++; if (fb_ready !== 1'b1) begin errors++; $display("FAIL hs_idle_rdy: got %b want 1", fb_ready); end
    fb_data = fa; fb_valid = 1'b1;
    @(negedge clk);
    fb_valid = 1'b0;
    checks++; if (fb_ready !== 1'b0) begin errors++; $display("FAIL hs_rdy_drop: got %b want 0", fb_ready); end
    wait_off(25);
    fb_data = fbb; fb_valid = 1'b1;
    repeat (2) @(negedge clk);
    fb_valid = 1'b0;
    checks++; if (fb_ready !== 1'b0) begin errors++; $display("FAIL hs_pending_rdy: got %b want 0", fb_ready); end
    for (int k = 28; k <= 39; k++) begin
      @(negedge clk);
      o = cur_off();
      checks++; if (rows !== 8'h00) begin errors++; $display("FAIL hs_old_rows o=%0d: got %h want 00", o, rows); end
      checks++; if (fb_ready !== (o == 39)) begin errors++; $display("FAIL hs_rdy o=%0d: got %b want %b", o, fb_ready, (o == 39)); end
    end
    for (int k = 0; k <= 37; k++) begin
      @(negedge clk);
      o = cur_off();
      checks++; if (rows !== (pulse(o, 0, 0, 7) | pulse(o, 3, 6, 7))) begin errors++; $display("FAIL hs_new_rows o=%0d: got %h want %h", o, rows, pulse(o, 0, 0, 7) | pulse(o, 3, 6, 7)); end
      checks++; if (frame_start !== (o == 0)) begin errors++; $display("FAIL hs_fs o=%0d: got %b want %b", o, frame_start, (o == 0)); end
      checks++; if (fb_ready !== 1'b1) begin errors++; $display("FAIL hs_rdy_back o=%0d: got %b want 1", o, fb_ready); end
    end
  endtask

  // Frame C accepted on the column-0 boundary edge: visible only one frame later.
  task automatic test_boundary_capture();
    logic [FW-1:0] fc;
    int o;
    fc = '0; fc[(0 * NR + 5) * PB +: PB] = 3'd3;
    @(negedge clk);
    checks++; if (cur_off() != 38) begin errors++; $display("FAIL bnd_align: got offset %0d want 38", cur_off()); end
    checks++; if (fb_ready !== 1'b1) begin errors++; $display("FAIL bnd_rdy_pre: got %b want 1", fb_ready); end
    fb_data = fc; fb_valid = 1'b1;
    @(negedge clk);
    fb_valid = 1'b0;
    checks++; if (fb_ready !== 1'b0) begin errors++; $display("FAIL bnd_rdy_drop: got %b want 0", fb_ready); end
    for (int k = 0; k <= 39; k++) begin
      @(negedge clk);
      o = cur_off();
      checks++; if (rows !== (pulse(o, 0, 0, 7) | pulse(o, 3, 6, 7))) begin errors++; $display("FAIL bnd_old_rows o=%0d: got %h want %h", o, rows, pulse(o, 0, 0, 7) | pulse(o, 3, 6, 7)); end
      checks++; if (fb_ready !== (o == 39)) begin errors++; $display("FAIL bnd_rdy o=%0d: got %b want %b", o, fb_ready, (o == 39)); end
    end
    for (int k = 0; k <= 39; k++) begin
      @(negedge clk);
      o = cur_off();
      checks++; if (rows !== pulse(o, 0, 5, 3)) begin errors++; $display("FAIL bnd_new_rows o=%0d: got %h want %h", o, rows, pulse(o, 0, 5, 3)); end
    end
  endtask

  task automatic test_reset_mid_on();
    logic [FW-1:0] fd;
    int o;
    fd = '0; fd[(0 * NR + 1) * PB +: PB] = 3'd7;
    wait_off(22);
    fb_data = fd; fb_valid = 1'b1;
    @(negedge clk);
    fb_valid = 1'b0;
    checks++; if (fb_ready !== 1'b0) begin errors++; $display("FAIL rst_pending_rdy: got %b want 0", fb_ready); end
    @(negedge clk);
    checks++; if (cols !== 4'b1011) begin errors++; $display("FAIL rst_pre_cols: got %h want b", cols); end
    #1 rst = 1'b1;
    #1;
    checks++; if (rows !== 8'h00) begin errors++; $display("FAIL rst_async_rows: got %h want 00", rows); end
    checks++; if (cols !== 4'hF) begin errors++; $display("FAIL rst_async_cols: got %h want f", cols); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_async_fs: got %b want 0", frame_start); end
    checks++; if (fb_ready !== 1'b1) begin errors++; $display("FAIL rst_async_rdy: got %b want 1", fb_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL rst_restart_fs: got %b want 1", frame_start); end
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      o = cur_off();
      checks++; if (cols !== exp_cols(o)) begin errors++; $display("FAIL rst_scan_cols o=%0d: got %h want %h", o, cols, exp_cols(o)); end
      checks++; if (rows !== 8'h00) begin errors++; $display("FAIL rst_scan_rows o=%0d: got %h want 00", o, rows); end
      checks++; if (fb_ready !== 1'b1) begin errors++; $display("FAIL rst_scan_rdy o=%0d: got %b want 1", o, fb_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_pwm_duty();
    test_global_dim();
    test_back_to_back();
    test_boundary_capture();
    test_reset_mid_on();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
